// File: rtl/rv32i_debug_pkg.sv
// Shared constants for the rv32i debug GPIO peripheral: register offsets and
// default window / identification values.
package rv32i_debug_pkg;

    localparam logic [15:0] BASE_HI_DEFAULT  = 16'hE001;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA1B2_C3D4;

    localparam logic [15:0] OFF_BTN   = 16'h0000;
    localparam logic [15:0] OFF_ID    = 16'h0004;
    localparam logic [15:0] OFF_LED   = 16'h0008;
    localparam logic [15:0] OFF_SET   = 16'h000C;
    localparam logic [15:0] OFF_CLR   = 16'h0010;
    localparam logic [15:0] OFF_TGL   = 16'h0014;
    localparam logic [15:0] OFF_EDGE  = 16'h0018;
    localparam logic [15:0] OFF_IRQEN = 16'h001C;

endpackage

// File: rtl/rv32i_debounce.sv
// One button channel: 2-FF synchroniser, stability counter and a combinational
// rise strobe that is high on the same edge the debounced level goes 0->1.
module rv32i_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;
    logic          accept_c;

    // New level has been stable long enough and is taken on this edge.
    assign accept_c = (sync_q2 != dout) && (cnt == CNT_LAST);
    assign rise     = accept_c && sync_q2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            dout    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            if (sync_q2 == dout) begin
                cnt <= '0;
            end else if (accept_c) begin
                dout <= sync_q2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rv32i_debug_gpio.sv
// Memory-mapped debug GPIO: debounced buttons with sticky press flags and a
// maskable interrupt, plus LEDs with set/clear/toggle, on the rv32i data bus.
module rv32i_debug_gpio
    import rv32i_debug_pkg::*;
#(
    parameter logic [15:0] BASE_HI    = BASE_HI_DEFAULT,
    parameter int unsigned NBTN       = 8,
    parameter int unsigned NLED       = 8,
    parameter int unsigned DEB_CYCLES = 4,
    parameter logic [31:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic            we,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NBTN-1:0] btn_in,
    output logic [NLED-1:0] led_out,
    output logic            irq
);

    logic            hit_c;
    logic            rd_c;
    logic            wr_c;
    logic [15:0]     off_c;
    logic [NBTN-1:0] deb;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] edge_flags;
    logic [NBTN-1:0] irq_en;
    logic [NLED-1:0] led_d;
    logic [NBTN-1:0] edge_d;
    logic [NBTN-1:0] irq_en_d;
    logic [31:0]     rdata_d;
    logic            unused_wdata_c;

    assign hit_c = cs && (addr[31:16] == BASE_HI);
    assign rd_c  = hit_c && !we;
    assign wr_c  = hit_c && we;
    assign off_c = addr[15:0];

    // Bits above NLED/NBTN are ignored on writes.
    assign unused_wdata_c = ^wdata;

    for (genvar i = 0; i < int'(NBTN); i++) begin : g_btn
        rv32i_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk (clk),
            .rst (rst),
            .din (btn_in[i]),
            .dout(deb[i]),
            .rise(rise[i])
        );
    end

    // Register writes and read mux; a new rise always beats a W1C clear.
    always_comb begin
        led_d    = led_out;
        edge_d   = edge_flags | rise;
        irq_en_d = irq_en;
        rdata_d  = '0;
        if (wr_c) begin
            case (off_c)
                OFF_BTN,
                OFF_LED:   led_d    = wdata[NLED-1:0];
                OFF_SET:   led_d    = led_out | wdata[NLED-1:0];
                OFF_CLR:   led_d    = led_out & ~wdata[NLED-1:0];
                OFF_TGL:   led_d    = led_out ^ wdata[NLED-1:0];
                OFF_EDGE:  edge_d   = (edge_flags & ~wdata[NBTN-1:0]) | rise;
                OFF_IRQEN: irq_en_d = wdata[NBTN-1:0];
                default:   ;
            endcase
        end
        if (rd_c) begin
            case (off_c)
                OFF_BTN:   rdata_d = 32'(deb);
                OFF_ID:    rdata_d = ID_VALUE;
                OFF_LED:   rdata_d = 32'(led_out);
                OFF_EDGE:  rdata_d = 32'(edge_flags);
                OFF_IRQEN: rdata_d = 32'(irq_en);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata      <= '0;
            led_out    <= '0;
            edge_flags <= '0;
            irq_en     <= '0;
            irq        <= 1'b0;
        end else begin
            rdata      <= rdata_d;
            led_out    <= led_d;
            edge_flags <= edge_d;
            irq_en     <= irq_en_d;
            irq        <= |(edge_flags & irq_en);
        end
    end

endmodule

// File: tb/tb_rv32i_debug_gpio.sv
// Directed bench for rv32i_debug_gpio with default parameters (DEB_CYCLES=4).
module tb_rv32i_debug_gpio;
    import rv32i_debug_pkg::*;

    localparam logic [31:0] BASE = 32'hE001_0000;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  btn_in;
    logic [7:0]  led_out;
    logic        irq;

    int checks;
    int errors;

    rv32i_debug_gpio dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .btn_in (btn_in),
        .led_out(led_out),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] d);
        cs    = 1'b1;
        we    = 1'b1;
        addr  = BASE | 32'(off);
        wdata = d;
        tick();
        cs    = 1'b0;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        cs   = 1'b1;
        we   = 1'b0;
        addr = a;
        tick();
        check(tag, rdata, exp);
        cs   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        cs     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        btn_in = '0;

        // Reset and legacy/miss reads
        tick();
        tick();
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b1;
        rd(BASE | 32'h4, 32'hA1B2_C3D4, "id_read");
        cs = 1'b0; we = 1'b0; addr = BASE | 32'h4;
        tick();
        check("cs_low_read", rdata, 32'h0);
        rd(BASE | 32'h4, 32'hA1B2_C3D4, "id_read2");
        rd(32'hE002_0000, 32'h0, "miss_read");

        // LED operations
        wr(OFF_LED, 32'h0F);   check("led_write", 32'(led_out), 32'h0F);
        wr(OFF_SET, 32'hF0);   check("led_set", 32'(led_out), 32'hFF);
        wr(OFF_CLR, 32'h03);   check("led_clr", 32'(led_out), 32'hFC);
        wr(OFF_TGL, 32'h81);   check("led_tgl", 32'(led_out), 32'h7D);
        wr(OFF_BTN, 32'h55);   check("led_legacy", 32'(led_out), 32'h55);
        rd(BASE | 32'(OFF_LED), 32'h55, "led_read");
        rd(BASE | 32'(OFF_SET), 32'h0, "set_reads_zero");
        wr(OFF_ID, 32'hFF);    check("id_write_ignored", 32'(led_out), 32'h55);
        wr(OFF_LED, 32'h1234_5678); check("led_upper_ignored", 32'(led_out), 32'h78);
        rd(BASE | 32'h40, 32'h0, "unmapped_read");

        // Short glitch on btn 2 never reaches the debounced state
        btn_in = 8'h04;
        repeat (3) tick();
        btn_in = 8'h00;
        repeat (8) tick();
        rd(BASE | 32'(OFF_BTN), 32'h0, "glitch_btn");
        rd(BASE | 32'(OFF_EDGE), 32'h0, "glitch_edge");

        // Press latency: deb at k+5, irq at k+6
        wr(OFF_IRQEN, 32'h04);
        rd(BASE | 32'(OFF_IRQEN), 32'h04, "irqen_read");
        btn_in = 8'h04;
        repeat (4) tick();
        cs = 1'b1; we = 1'b0; addr = BASE | 32'(OFF_BTN);
        tick();
        check("press_k4_btn", rdata, 32'h0);
        check("press_k4_irq", 32'(irq), 32'h0);
        tick();
        check("press_k5_btn", rdata, 32'h0);
        check("press_k5_irq", 32'(irq), 32'h0);
        tick();
        check("press_k6_btn", rdata, 32'h04);
        check("press_k6_irq", 32'(irq), 32'h1);
        cs = 1'b0;
        rd(BASE | 32'(OFF_EDGE), 32'h04, "press_edge");

        // W1C drops irq one cycle later
        wr(OFF_EDGE, 32'h04);
        check("w1c_irq_same", 32'(irq), 32'h1);
        tick();
        check("w1c_irq_next", 32'(irq), 32'h0);
        rd(BASE | 32'(OFF_EDGE), 32'h0, "w1c_edge");

        // Release sets no edge flag
        btn_in = 8'h00;
        repeat (8) tick();
        rd(BASE | 32'(OFF_BTN), 32'h0, "release_btn");
        rd(BASE | 32'(OFF_EDGE), 32'h0, "release_edge");
        check("release_irq", 32'(irq), 32'h0);

        // W1C on the same edge as a new rise: set wins
        btn_in = 8'h04;
        repeat (5) tick();
        wr(OFF_EDGE, 32'h04);
        check("coinc_irq_same", 32'(irq), 32'h0);
        rd(BASE | 32'(OFF_EDGE), 32'h04, "coinc_edge");
        check("coinc_irq_next", 32'(irq), 32'h1);

        // Reset during a debounce in progress
        btn_in = 8'h00;
        repeat (8) tick();
        wr(OFF_LED, 32'hAA);
        btn_in = 8'h02;
        cs = 1'b1; we = 1'b0; addr = BASE | 32'(OFF_LED);
        repeat (3) tick();
        check("pre_rst_rdata", rdata, 32'hAA);
        rst = 1'b0;
        tick();
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_led", 32'(led_out), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        rst = 1'b1;
        wr(OFF_IRQEN, 32'h02);
        cs = 1'b1; we = 1'b0; addr = BASE | 32'(OFF_EDGE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("post_rst_edge_%0d", i), rdata, 32'h0);
            check($sformatf("post_rst_irq_%0d", i), 32'(irq), 32'h0);
        end
        tick();
        check("post_rst_edge_set", rdata, 32'h02);
        check("post_rst_irq_set", 32'(irq), 32'h1);
        cs = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
